// File: rtl/fcs_strip_shift_ctrl.sv
// fcs_strip_shift_ctrl: sequences an external DEPTH-stage shift register to strip trailing FCS bytes
module fcs_strip_shift_ctrl #(
    parameter int DATAW = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sr_enable,
    output logic [DATAW-1:0] sr_data_in,
    input  logic [DATAW-1:0] sr_data_out,
    output logic             runt_err
);
    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    localparam logic [CNTW-1:0] FULL_OCC = CNTW'(DEPTH);

    state_t             state;
    logic [CNTW-1:0]    occ, occ_nxt;
    logic               acc, emit, drain;
    logic               valid_nxt, last_nxt, runt_nxt;
    logic [DATAW-1:0]   data_nxt;

    assign sr_enable  = acc;
    assign sr_data_in = in_data;

    // state is decoded from occupancy; the register contents never decide validity
    always_comb begin
        state     = occ == '0 ? IDLE : (occ == FULL_OCC ? FULL : FILL);
        in_ready  = !flush && (state != FULL || !out_valid || out_ready);
        acc       = in_valid && in_ready;
        emit      = acc && state == FULL;
        drain     = out_valid && out_ready;
        occ_nxt   = (flush || (acc && in_last)) ? '0 : ((acc && state != FULL) ? occ + 1'b1 : occ);
        runt_nxt  = acc && in_last && state != FULL;
        valid_nxt = emit || (out_valid && !out_ready);
        last_nxt  = emit ? in_last : (drain ? 1'b0 : out_last);
        data_nxt  = emit ? sr_data_out : out_data;
    end

    // occupancy counter, registered output stage and runt pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            runt_err  <= 1'b0;
        end else begin
            occ       <= occ_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_last  <= last_nxt;
            runt_err  <= runt_nxt;
        end
    end
endmodule

// File: tb/tb_fcs_strip_shift_ctrl.sv
// tb_fcs_strip_shift_ctrl: randomized and directed scoreboard bench for the FCS strip controller
module tb_fcs_strip_shift_ctrl;
    localparam int DATAW = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_last, sr_enable, runt_err;
    logic [7:0] out_data, sr_data_in, sr_data_out;
    logic [7:0] sr [DEPTH];

    beat_t      exp_q[$];
    logic [7:0] frame_q[$];
    beat_t      mon_e;
    int         checks = 0;
    int         errors = 0;
    int         exp_runt = 0;
    int         got_runt = 0;
    int         stall = 0;
    bit         rnd_ready = 1'b0;
    bit         arm_stall = 1'b0;

    fcs_strip_shift_ctrl #(.DATAW(DATAW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .sr_enable(sr_enable), .sr_data_in(sr_data_in), .sr_data_out(sr_data_out),
        .runt_err(runt_err)
    );

    always #5 clk = ~clk;

    // external shift register the controller sequences; oldest entry at the far end
    always @(posedge clk) begin
        if (sr_enable) begin
            for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= sr_data_in;
        end
    end
    assign sr_data_out = sr[DEPTH-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every delivered beat and counts runt pulse cycles
    always @(negedge clk) begin
        if (reset) begin
            if (runt_err) got_runt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %0h with no beat expected", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.d));
                    check("out_last", 32'(out_last), 32'(mon_e.l));
                end
            end
        end
    end

    // one clock of stimulus; the reference model is a per-frame byte list where byte k
    // becomes payload once byte k+DEPTH arrives, and a frame of <= DEPTH bytes is a runt
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic f, output logic acc);
        int    n;
        logic  emitted;
        beat_t e;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        flush     = f;
        out_ready = stall > 0 ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        if (stall > 0) stall--;
        emitted = 1'b0;
        e = '0;
        @(negedge clk);
        acc = v && in_ready;
        n = frame_q.size();
        check("sr_enable", 32'(sr_enable), 32'(acc));
        check("sr_data_in", 32'(sr_data_in), 32'(d));
        if (f) check("in_ready_flush", 32'(in_ready), 32'(0));
        else if (n < DEPTH) check("in_ready_fill", 32'(in_ready), 32'(1));
        else check("in_ready_full", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (f) frame_q.delete();
        else if (acc) begin
            frame_q.push_back(d);
            n = frame_q.size();
            if (n > DEPTH) begin
                e.d = frame_q[n-1-DEPTH];
                e.l = l;
                exp_q.push_back(e);
                emitted = 1'b1;
            end
            if (l) begin
                if (n <= DEPTH) exp_runt++;
                frame_q.delete();
            end
        end
        @(posedge clk);
        #1;
        if (emitted) begin
            check("emit_valid", 32'(out_valid), 32'(1));
            check("emit_data", 32'(out_data), 32'(e.d));
            check("emit_last", 32'(out_last), 32'(e.l));
            if (arm_stall) begin
                arm_stall = 1'b0;
                stall = 3;
            end
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        logic a;
        int   tries;
        tries = 0;
        do begin
            cycle(1'b1, d, l, 1'b0, a);
            tries++;
        end while (!a && tries < 50);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %0h not accepted in %0d cycles", d, tries);
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) send_byte(8'(base + 8'(i)), i == len - 1);
    endtask

    task automatic reset_pulse();
        in_valid = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_runt_err", 32'(runt_err), 32'(0));
        frame_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic a;
        int   len;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();
        // reset mid-frame, then a fresh frame must not leak stale bytes
        send_byte(8'h50, 1'b0);
        send_byte(8'h51, 1'b0);
        reset_pulse();
        send_frame(8'h10, 6);
        idle(2);
        // normal 10-byte frame
        send_frame(8'h01, 10);
        idle(2);
        // minimum frame then runt
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b1);
        send_frame(8'h01, 4);
        idle(2);
        // backpressure after first emit
        arm_stall = 1'b1;
        send_frame(8'h01, 8);
        idle(2);
        // flush mid-frame with in_valid high
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
        cycle(1'b1, 8'h07, 1'b0, 1'b1, a);
        check("flush_accept", 32'(a), 32'(0));
        send_frame(8'h20, 6);
        // back-to-back frames
        send_frame(8'h30, 6);
        send_frame(8'h40, 6);
        idle(3);
        // randomized frames, gaps, backpressure and flushes
        rnd_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                if ($urandom_range(0, 40) == 0) begin
                    cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b1, a);
                    break;
                end
                send_byte(8'($urandom), i == len - 1);
            end
        end
        rnd_ready = 1'b0;
        idle(10);
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        check("runt_count", 32'(got_runt), 32'(exp_runt));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
